// File: rtl/adpll_lock_detector.sv
// adpll_lock_detector
// Hysteretic lock qualifier for the ring ADPLL phase-error word.
// - Detects rising edges of the asynchronous reference clock.
// - Samples the signed error once per reference period.
// - Runs an UNLOCKED/ACQUIRING/LOCKED/SLIPPING state machine.
// - Holds the peak |error| seen since lock was last entered.
// - Flags loss of the reference clock.
//
// Strobe handshake: a strobe is a one-cycle pulse, and it is consumed only
// when enable_i is high in that same cycle. There is no back-pressure;
// a strobe seen while enable_i is low is dropped.
module adpll_lock_detector #(
  parameter int WIDTH        = 8,
  parameter int LOCK_WINDOW  = 4,
  parameter int LOCK_COUNT   = 16,
  parameter int UNLOCK_COUNT = 4,
  parameter int REF_TIMEOUT  = 128
) (
  input  logic             fpga_clk_i,
  input  logic             reset_i,
  input  logic             enable_i,
  input  logic             ref_clk_i,
  input  logic [WIDTH-1:0] error_i,
  output logic             locked_o,
  output logic [1:0]       lock_state_o,
  output logic [WIDTH:0]   peak_err_o,
  output logic             ref_lost_o
);

  // The sequence counter is at least 8 bits wide. It is widened when
  // either count threshold needs more bits.
  localparam int CNT_MAX_REQ = (LOCK_COUNT > UNLOCK_COUNT) ? LOCK_COUNT : UNLOCK_COUNT;
  localparam int CNT_W       = ($clog2(CNT_MAX_REQ + 1) > 8) ? $clog2(CNT_MAX_REQ + 1) : 8;
  localparam int TO_W        = $clog2(REF_TIMEOUT + 1);

  localparam logic [CNT_W-1:0] LOCK_CNT_V   = CNT_W'(LOCK_COUNT);
  localparam logic [CNT_W-1:0] UNLOCK_CNT_V = CNT_W'(UNLOCK_COUNT);
  localparam logic [WIDTH:0]   WIN_V        = (WIDTH+1)'(LOCK_WINDOW);
  localparam logic [TO_W-1:0]  TO_MAX       = TO_W'(REF_TIMEOUT);
  localparam logic [TO_W-1:0]  TO_LAST      = TO_W'(REF_TIMEOUT - 1);

  typedef enum logic [1:0] {
    ST_UNLOCKED  = 2'b00,
    ST_ACQUIRING = 2'b01,
    ST_LOCKED    = 2'b10,
    ST_SLIPPING  = 2'b11
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [WIDTH:0]   r_peak, w_peak_nxt;
  logic [TO_W-1:0]  r_to, w_to_nxt;
  logic             r_ref_lost, w_ref_lost_nxt;
  logic             r_sync1, r_sync2, r_sync3;

  logic             w_strobe;
  logic [WIDTH:0]   w_err_ext;
  logic [WIDTH:0]   w_mag;
  logic             w_in_win;
  logic [CNT_W-1:0] w_cnt_inc;
  logic [WIDTH:0]   w_peak_max;

  // Synchronise the reference clock, plus one extra flop for edge detection.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
    end else begin
      r_sync1 <= ref_clk_i;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
    end
  end

  assign w_strobe = r_sync2 & ~r_sync3;

  // Compute the magnitude one bit wider than the input, so the most
  // negative code maps to +2^(WIDTH-1) with no wrap.
  assign w_err_ext  = {error_i[WIDTH-1], error_i};
  assign w_mag      = error_i[WIDTH-1] ? (~w_err_ext + 1'b1) : w_err_ext;
  assign w_in_win   = (w_mag <= WIN_V);
  assign w_cnt_inc  = r_cnt + 1'b1;
  assign w_peak_max = (w_mag > r_peak) ? w_mag : r_peak;

  // State, counter, peak, timeout and ref_lost registers.
  always_ff @(posedge fpga_clk_i or posedge reset_i) begin
    if (reset_i) begin
      r_state    <= ST_UNLOCKED;
      r_cnt      <= '0;
      r_peak     <= '0;
      r_to       <= '0;
      r_ref_lost <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_cnt      <= w_cnt_nxt;
      r_peak     <= w_peak_nxt;
      r_to       <= w_to_nxt;
      r_ref_lost <= w_ref_lost_nxt;
    end
  end

  // Next-state logic. When a strobe and the timeout coincide, the strobe
  // takes priority and the counter clears with no forced unlock.
  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_peak_nxt     = r_peak;
    w_to_nxt       = r_to;
    w_ref_lost_nxt = r_ref_lost;
    if (!enable_i) begin
      w_to_nxt = '0;
    end else if (w_strobe) begin
      w_to_nxt       = '0;
      w_ref_lost_nxt = 1'b0;
      case (r_state)
        ST_UNLOCKED: begin
          if (w_in_win) begin
            w_state_nxt = ST_ACQUIRING;
            w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
          end else begin
            w_cnt_nxt = '0;
          end
        end
        ST_ACQUIRING: begin
          if (!w_in_win) begin
            w_state_nxt = ST_UNLOCKED;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == LOCK_CNT_V) begin
            w_state_nxt = ST_LOCKED;
            w_cnt_nxt   = '0;
            w_peak_nxt  = w_mag;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
        ST_LOCKED: begin
          w_peak_nxt = w_peak_max;
          if (w_in_win) begin
            w_cnt_nxt = '0;
          end else begin
            w_state_nxt = ST_SLIPPING;
            w_cnt_nxt   = {{(CNT_W-1){1'b0}}, 1'b1};
          end
        end
        default: begin
          w_peak_nxt = w_peak_max;
          if (w_in_win) begin
            w_state_nxt = ST_LOCKED;
            w_cnt_nxt   = '0;
          end else if (w_cnt_inc == UNLOCK_CNT_V) begin
            w_state_nxt = ST_UNLOCKED;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = w_cnt_inc;
          end
        end
      endcase
    end else begin
      if (r_to != TO_MAX) begin
        w_to_nxt = r_to + 1'b1;
      end
      if (r_to == TO_LAST) begin
        w_ref_lost_nxt = 1'b1;
        w_state_nxt    = ST_UNLOCKED;
        w_cnt_nxt      = '0;
      end
    end
  end

  assign lock_state_o = r_state;
  assign locked_o     = r_state[1];
  assign peak_err_o   = r_peak;
  assign ref_lost_o   = r_ref_lost;

endmodule

// File: tb/tb_adpll_lock_detector.sv
`timescale 1ns/1ps
module tb_adpll_lock_detector;

  logic       fpga_clk_i = 1'b0;
  logic       reset_i    = 1'b1;
  logic       enable_i   = 1'b1;
  logic       ref_clk_i  = 1'b0;
  logic [7:0] error_i    = 8'd0;
  logic       locked_o;
  logic [1:0] lock_state_o;
  logic [8:0] peak_err_o;
  logic       ref_lost_o;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [1:0] S_UNL = 2'b00;
  localparam logic [1:0] S_ACQ = 2'b01;
  localparam logic [1:0] S_LCK = 2'b10;
  localparam logic [1:0] S_SLP = 2'b11;

  adpll_lock_detector dut (
    .fpga_clk_i  (fpga_clk_i),
    .reset_i     (reset_i),
    .enable_i    (enable_i),
    .ref_clk_i   (ref_clk_i),
    .error_i     (error_i),
    .locked_o    (locked_o),
    .lock_state_o(lock_state_o),
    .peak_err_o  (peak_err_o),
    .ref_lost_o  (ref_lost_o)
  );

  // About 258 MHz system clock.
  always #1.938 fpga_clk_i = ~fpga_clk_i;

  task automatic check(input string tag, input logic [8:0] got, input logic [8:0] exp);
    n_checks++;
    assert (got === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag, input logic [1:0] st, input logic lk,
                           input logic [8:0] pk, input logic rl);
    check({tag, ".state"}, {7'd0, lock_state_o}, {7'd0, st});
    check({tag, ".locked"}, {8'd0, locked_o}, {8'd0, lk});
    check({tag, ".peak"}, peak_err_o, pk);
    check({tag, ".ref_lost"}, {8'd0, ref_lost_o}, {8'd0, rl});
  endtask

  // One 52-cycle reference period (about 5 MHz), starting and ending on a
  // falling clock edge. The error word is held for the whole period.
  task automatic ref_period(input logic [7:0] e);
    error_i   = e;
    ref_clk_i = 1'b1;
    repeat (26) @(negedge fpga_clk_i);
    ref_clk_i = 1'b0;
    repeat (26) @(negedge fpga_clk_i);
  endtask

  task automatic ref_periods(input int n, input logic [7:0] e);
    for (int i = 0; i < n; i++) ref_period(e);
  endtask

  initial begin
    // Reset held.
    repeat (4) @(negedge fpga_clk_i);
    check_all("reset", S_UNL, 1'b0, 9'd0, 1'b0);
    reset_i = 1'b0;
    repeat (2) @(negedge fpga_clk_i);
    check_all("post_reset", S_UNL, 1'b0, 9'd0, 1'b0);

    // Acquire with zero error: ACQUIRING after the first strobe, LOCKED on the 16th.
    ref_period(8'd0);
    check_all("acq1", S_ACQ, 1'b0, 9'd0, 1'b0);
    ref_periods(14, 8'd0);
    check_all("acq15", S_ACQ, 1'b0, 9'd0, 1'b0);
    ref_period(8'd0);
    check_all("lock16", S_LCK, 1'b1, 9'd0, 1'b0);

    // In-window errors while locked update the peak.
    ref_period(8'd3);
    check_all("pk_p3", S_LCK, 1'b1, 9'd3, 1'b0);
    ref_period(8'hFC);   // -4, window edge
    check_all("pk_m4", S_LCK, 1'b1, 9'd4, 1'b0);

    // Three +5 samples slip without unlocking, then 0 relocks.
    ref_period(8'd5);
    check_all("slip1", S_SLP, 1'b1, 9'd5, 1'b0);
    ref_periods(2, 8'd5);
    check_all("slip3", S_SLP, 1'b1, 9'd5, 1'b0);
    ref_period(8'd0);
    check_all("relock", S_LCK, 1'b1, 9'd5, 1'b0);

    // Four out-of-window samples drop lock.
    ref_period(8'd6);
    ref_period(8'hFA);   // -6
    ref_period(8'd7);
    check_all("slip_b3", S_SLP, 1'b1, 9'd7, 1'b0);
    // Fourth strobe is checked around its update edge.
    error_i   = 8'hF6;   // -10
    ref_clk_i = 1'b1;
    repeat (2) @(negedge fpga_clk_i);
    check("unlock_pre_edge", {8'd0, locked_o}, 9'd1);
    @(negedge fpga_clk_i);
    check("unlock_post_edge", {8'd0, locked_o}, 9'd0);
    repeat (23) @(negedge fpga_clk_i);
    ref_clk_i = 1'b0;
    repeat (26) @(negedge fpga_clk_i);
    check_all("unlocked", S_UNL, 1'b0, 9'd10, 1'b0);

    // -128 during acquisition at cnt=10 aborts; a full fresh run is needed.
    ref_periods(10, 8'd0);
    check_all("acq10", S_ACQ, 1'b0, 9'd10, 1'b0);
    ref_period(8'h80);
    check_all("abort_m128", S_UNL, 1'b0, 9'd10, 1'b0);
    ref_periods(15, 8'd1);
    check_all("reacq15", S_ACQ, 1'b0, 9'd10, 1'b0);
    ref_period(8'd2);
    check_all("relock16", S_LCK, 1'b1, 9'd2, 1'b0);
    // -128 while locked: magnitude 128 with no wrap.
    ref_period(8'h80);
    check_all("mag128", S_SLP, 1'b1, 9'd128, 1'b0);
    ref_period(8'd0);
    check_all("relock_pk128", S_LCK, 1'b1, 9'd128, 1'b0);

    // Reference stops. The last strobe updates on the 3rd rising edge of
    // its period; 49 rising edges remain in that period, so 78 more here
    // leave the timeout at 127, and one edge later it trips.
    ref_period(8'd0);
    repeat (78) @(negedge fpga_clk_i);
    check_all("to_127", S_LCK, 1'b1, 9'd128, 1'b0);
    @(negedge fpga_clk_i);
    check_all("to_128", S_UNL, 1'b0, 9'd128, 1'b1);
    repeat (40) @(negedge fpga_clk_i);
    check_all("to_hold", S_UNL, 1'b0, 9'd128, 1'b1);
    ref_period(8'd0);
    check_all("ref_back", S_ACQ, 1'b0, 9'd128, 1'b0);

    // Freeze at cnt=8 with enable low. Ignored strobes include out-of-window ones.
    ref_periods(7, 8'd0);
    enable_i = 1'b0;
    ref_periods(10, 8'd0);
    ref_periods(10, 8'h64);
    check_all("frozen", S_ACQ, 1'b0, 9'd128, 1'b0);
    enable_i = 1'b1;
    ref_periods(7, 8'd0);
    check_all("resume7", S_ACQ, 1'b0, 9'd128, 1'b0);
    ref_period(8'd3);
    check_all("resume8", S_LCK, 1'b1, 9'd3, 1'b0);

    // Asynchronous reset mid-lock clears outputs before any clock edge.
    reset_i = 1'b1;
    #0.2;
    check_all("async_rst", S_UNL, 1'b0, 9'd0, 1'b0);
    repeat (3) @(negedge fpga_clk_i);
    reset_i = 1'b0;
    ref_period(8'd0);
    check_all("after_rst", S_ACQ, 1'b0, 9'd0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
